fp_div: RTL and testbench

//  Sequential IEEE-754 binary16 divider, oZ = iA / iB; inverse companion of the combinational FP multiplier.

---
 rtl/fp16_pkg.sv | 40 ++++
 rtl/fp_div_if.sv | 23 ++
 rtl/fp_div_lzc11.sv | 17 +
 rtl/fp_div.sv | 188 ++++++++++++++++++
 tb/tb_fp_div.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 constants, FSM state encoding and operand layout for the FP divider.
package fp16_pkg;

  localparam int unsigned BITS      = 16;
  localparam int unsigned E_BITS    = 5;
  localparam int unsigned M_BITS    = 11;
  localparam int unsigned F_BITS    = M_BITS - 1;
  localparam int unsigned Q_BITS    = M_BITS + 2;
  localparam int unsigned R_BITS    = M_BITS + 1;
  localparam int unsigned X_BITS    = 8;
  localparam int unsigned LZ_BITS   = 4;
  localparam int unsigned CNT_BITS  = 4;
  localparam int unsigned FLAG_BITS = 5;
  localparam int unsigned BIAS      = 15;
  localparam int unsigned EXP_MAX   = 31;

  localparam logic [BITS-1:0] QNAN = 16'hFE00;
  localparam logic [BITS-1:0] PINF = 16'h7C00;

  typedef enum logic [2:0] {IDLE, PREP, DIV, RND, DONE} state_t;

  typedef struct packed {
    logic              sign;
    logic [E_BITS-1:0] exp;
    logic [F_BITS-1:0] man;
  } fp16_t;

  function automatic logic is_nan(input fp16_t x);
    return (&x.exp) && (|x.man);
  endfunction

  function automatic logic is_inf(input fp16_t x);
    return (&x.exp) && !(|x.man);
  endfunction

  function automatic logic is_zero(input fp16_t x);
    return !(|x.exp) && !(|x.man);
  endfunction

endpackage

// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for fp_div; oFlags exists only when FP_DIV_FLAGS_EN is defined.
interface fp_div_if;
  import fp16_pkg::*;

  logic            iValid;
  logic            oReady;
  logic [BITS-1:0] iA;
  logic [BITS-1:0] iB;
  logic            oValid;
  logic            iReady;
  logic [BITS-1:0] oZ;

`ifdef FP_DIV_FLAGS_EN
  logic [FLAG_BITS-1:0] oFlags;

  modport master (output iValid, iA, iB, iReady, input oReady, oValid, oZ, oFlags);
  modport slave  (input iValid, iA, iB, iReady, output oReady, oValid, oZ, oFlags);
`else
  modport master (output iValid, iA, iB, iReady, input oReady, oValid, oZ);
  modport slave  (input iValid, iA, iB, iReady, output oReady, oValid, oZ);
`endif

endinterface

// File: rtl/fp_div_lzc11.sv
// Leading-zero count of an 11-bit significand, used to normalise subnormal operands.
module lzc11
  import fp16_pkg::*;
(
  input  logic [M_BITS-1:0]  man,
  output logic [LZ_BITS-1:0] lz
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    lz = LZ_BITS'(M_BITS);
    for (int i = 0; i < M_BITS; i++) begin
      if (man[i]) lz = LZ_BITS'(M_BITS - 1 - i);
    end
  end

endmodule

// File: rtl/fp_div.sv
// Sequential binary16 divider: restoring radix-2, one quotient bit per clock, RNE, subnormals.
// Define FP_DIV_FLAGS_EN to add the registered exception flags {invalid,divzero,overflow,underflow,inexact}.
module fp_div
  import fp16_pkg::*;
(
  input logic     iClk,
  input logic     iRst_n,
  fp_div_if.slave bus
);

  state_t state, state_n;

  fp16_t                a_q, b_q;
  logic [X_BITS-1:0]    exp_q;
  logic [R_BITS-1:0]    rem_q;
  logic [M_BITS-1:0]    div_q;
  logic [Q_BITS-1:0]    quo_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic                 ready_q, valid_q;
  logic [BITS-1:0]      z_q;

  fp16_t           ia, ib;
  logic            accept;
  logic            spec_hit;
  logic [BITS-1:0] spec_z;

  assign ia     = bus.iA;
  assign ib     = bus.iB;
  assign accept = ready_q && bus.iValid;

  // Special operands resolve at accept time, in priority order.
  always_comb begin : special_decode
    logic s;
    s        = ia.sign ^ ib.sign;
    spec_hit = 1'b1;
    spec_z   = '0;
    if (is_nan(ia) || is_nan(ib) || (is_zero(ia) && is_zero(ib)) || (is_inf(ia) && is_inf(ib)))
      spec_z = QNAN;
    else if (is_inf(ia) || is_zero(ib))
      spec_z = {s, PINF[BITS-2:0]};
    else if (is_zero(ia) || is_inf(ib))
      spec_z = {s, {(BITS-1){1'b0}}};
    else
      spec_hit = 1'b0;
  end

  logic [M_BITS-1:0]  man_a, man_b, norm_a, norm_b;
  logic [LZ_BITS-1:0] lz_a, lz_b;
  logic [E_BITS-1:0]  ea, eb;
  logic [X_BITS-1:0]  e_raw;
  logic               a_lt;

  assign man_a = {|a_q.exp, a_q.man};
  assign man_b = {|b_q.exp, b_q.man};

  lzc11 u_lzc_a (.man(man_a), .lz(lz_a));
  lzc11 u_lzc_b (.man(man_b), .lz(lz_b));

  // Subnormals behave as exponent 1 with a denormal significand, then get left-justified.
  assign ea     = (a_q.exp == '0) ? E_BITS'(1) : a_q.exp;
  assign eb     = (b_q.exp == '0) ? E_BITS'(1) : b_q.exp;
  assign norm_a = man_a << lz_a;
  assign norm_b = man_b << lz_b;
  assign e_raw  = X_BITS'(ea) - X_BITS'(eb) + X_BITS'(BIAS) - X_BITS'(lz_a) + X_BITS'(lz_b);
  assign a_lt   = norm_a < norm_b;

  logic [R_BITS-1:0] div_ext, diff, rem_next;
  logic              ge;

  assign div_ext  = {1'b0, div_q};
  assign ge       = rem_q >= div_ext;
  assign diff     = rem_q - div_ext;
  assign rem_next = ge ? {diff[M_BITS-1:0], 1'b0} : {rem_q[M_BITS-1:0], 1'b0};

  logic signed [X_BITS-1:0] exp_s;
  logic [X_BITS-1:0]        sh;
  logic [Q_BITS-1:0]        grs, lost;
  logic                     tiny, ovf_pre, sticky, rnd_up;
  logic [E_BITS-1:0]        exp_f;
  logic [BITS-2:0]          mag;
  logic [BITS-1:0]          rnd_z;

  assign exp_s   = $signed(exp_q);
  assign tiny    = exp_s < $signed(X_BITS'(1));
  assign ovf_pre = exp_s > $signed(X_BITS'(EXP_MAX - 1));
  assign sh      = X_BITS'(1) - exp_q;

  // Denormalising shift pushes dropped bits into sticky; the leading quotient bit survives only when normal.
  always_comb begin : round_stage
    grs  = quo_q;
    lost = '0;
    if (tiny) begin
      grs  = quo_q >> sh;
      lost = quo_q & ~({Q_BITS{1'b1}} << sh);
    end
    sticky = (|rem_q) || (|lost);
    rnd_up = grs[1] && (grs[0] || sticky || grs[2]);
    exp_f  = grs[Q_BITS-1] ? exp_q[E_BITS-1:0] : '0;
    mag    = {exp_f, grs[Q_BITS-2:2]} + (BITS-1)'(rnd_up);
    if (ovf_pre) rnd_z = {a_q.sign ^ b_q.sign, PINF[BITS-2:0]};
    else         rnd_z = {a_q.sign ^ b_q.sign, mag};
  end

  always_comb begin : fsm_next
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = spec_hit ? DONE : PREP;
      PREP:    state_n = DIV;
      DIV:     if (cnt_q == CNT_BITS'(Q_BITS - 1)) state_n = RND;
      RND:     state_n = DONE;
      DONE:    if (bus.iReady) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin : state_reg
    if (!iRst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge iClk) begin : datapath
    if (!iRst_n) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      z_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= (state_n == IDLE);
      valid_q <= (state_n == DONE);
      case (state)
        IDLE: if (accept) begin
          a_q <= ia;
          b_q <= ib;
          if (spec_hit) z_q <= spec_z;
        end
        PREP: begin
          exp_q <= a_lt ? e_raw - X_BITS'(1) : e_raw;
          rem_q <= a_lt ? {norm_a, 1'b0} : {1'b0, norm_a};
          div_q <= norm_b;
          quo_q <= '0;
          cnt_q <= '0;
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[Q_BITS-2:0], ge};
          cnt_q <= cnt_q + CNT_BITS'(1);
        end
        RND:     z_q <= rnd_z;
        default: ;
      endcase
    end
  end

  assign bus.oReady = ready_q;
  assign bus.oValid = valid_q;
  assign bus.oZ     = z_q;

`ifdef FP_DIV_FLAGS_EN
  logic [FLAG_BITS-1:0] flags_q, spec_flags, rnd_flags;
  logic                 rnd_inexact;

  always_comb begin : flag_calc
    spec_flags  = '0;
    if (spec_hit) begin
      spec_flags[4] = (spec_z == QNAN);
      spec_flags[3] = is_zero(ib) && (spec_z != QNAN) && !is_inf(ia);
    end
    rnd_inexact = ovf_pre || grs[1] || grs[0] || sticky;
    rnd_flags   = {1'b0, 1'b0, ovf_pre || (&mag[BITS-2:F_BITS]), tiny && rnd_inexact, rnd_inexact};
  end

  // Flags are cleared on accept and land together with the rounded result.
  always_ff @(posedge iClk) begin : flag_reg
    if (!iRst_n)                      flags_q <= '0;
    else if (state == IDLE && accept) flags_q <= spec_flags;
    else if (state == RND)            flags_q <= rnd_flags;
  end

  assign bus.oFlags = flags_q;
`endif

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: vector table through a scoreboard, plus backpressure and mid-divide reset sequences.
module tb_fp_div;
  import fp16_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  fp_div_if bus ();

  fp_div dut (.iClk(clk), .iRst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] z;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] z;
    logic [4:0]  f;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Results are scored when the consumer is ready to take them.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.oValid && bus.iReady) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(bus.oZ), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("z", 32'(bus.oZ), 32'(e.z));
`ifdef FP_DIV_FLAGS_EN
        check("flags", 32'(bus.oFlags), 32'(e.f));
`endif
      end
    end
  end

  // Latency is counted in clock edges after the accepting edge.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] z,
                        input logic [4:0] f, input int lat);
    int n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!bus.oReady && n < 50) begin @(negedge clk); n++; end
    check("ready_before_op", 32'(bus.oReady), 32'd1);
    bus.iA = a; bus.iB = b; bus.iValid = 1'b1;
    @(posedge clk);
    e.z = z; e.f = f;
    sb.push_back(e);
    @(negedge clk);
    bus.iValid = 1'b0;
    n = 0;
    while (!bus.oValid && n < 40) begin @(negedge clk); n++; end
    check($sformatf("latency_%h_%h", a, b), 32'(n), 32'(lat));
    n = 0;
    while (bus.oValid && n < 40) begin @(negedge clk); n++; end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    exp_t e;
    vecs[0]  = '{16'h4200, 16'h3E00, 16'h4000, 5'b00000, 15};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, 5'b00001, 15};
    vecs[2]  = '{16'h8400, 16'h3C00, 16'h8400, 5'b00000, 15};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 0};
    vecs[4]  = '{16'h0000, 16'h0000, 16'hFE00, 5'b10000, 0};
    vecs[5]  = '{16'h7C00, 16'h7C00, 16'hFE00, 5'b10000, 0};
    vecs[6]  = '{16'h0000, 16'h4000, 16'h0000, 5'b00000, 0};
    vecs[7]  = '{16'h0400, 16'h4000, 16'h0200, 5'b00000, 15};
    vecs[8]  = '{16'h0001, 16'h4000, 16'h0000, 5'b00011, 15};
    vecs[9]  = '{16'h7BFF, 16'h3800, 16'h7C00, 5'b00101, 15};
    vecs[10] = '{16'h4500, 16'h4200, 16'h3EAB, 5'b00001, 15};
    vecs[11] = '{16'hC000, 16'h3C00, 16'hC000, 5'b00000, 15};
    vecs[12] = '{16'h7E00, 16'h3C00, 16'hFE00, 5'b10000, 0};
    vecs[13] = '{16'h3C00, 16'h7C00, 16'h0000, 5'b00000, 0};
    vecs[14] = '{16'h7C00, 16'hC000, 16'hFC00, 5'b00000, 0};
    vecs[15] = '{16'h3C00, 16'h0200, 16'h7800, 5'b00000, 15};

    rst_n = 1'b0; bus.iValid = 1'b0; bus.iReady = 1'b1; bus.iA = '0; bus.iB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(bus.oReady), 32'd1);
    check("reset_valid", 32'(bus.oValid), 32'd0);
    check("reset_z", 32'(bus.oZ), 32'd0);
`ifdef FP_DIV_FLAGS_EN
    check("reset_flags", 32'(bus.oFlags), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].f, vecs[i].lat);

    // Backpressure: result must hold while the consumer stalls, and new operands are ignored.
    @(posedge clk); #2 bus.iReady = 1'b0;
    @(negedge clk);
    bus.iA = 16'h3C00; bus.iB = 16'h4200; bus.iValid = 1'b1;
    @(posedge clk);
    e.z = 16'h3555; e.f = 5'b00001;
    sb.push_back(e);
    @(negedge clk);
    bus.iValid = 1'b0;
    n = 0;
    while (!bus.oValid && n < 40) begin @(negedge clk); n++; end
    check("bp_latency", 32'(n), 32'd15);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(bus.oValid), 32'd1);
      check("bp_z", 32'(bus.oZ), 32'h3555);
      check("bp_ready", 32'(bus.oReady), 32'd0);
`ifdef FP_DIV_FLAGS_EN
      check("bp_flags", 32'(bus.oFlags), 32'h01);
`endif
      bus.iA = 16'h4200; bus.iB = 16'h3E00; bus.iValid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #2 bus.iValid = 1'b0; bus.iReady = 1'b1;
    n = 0;
    while (!bus.oValid && n < 5) begin @(negedge clk); n++; end
    n = 0;
    while (bus.oValid && n < 5) begin @(negedge clk); n++; end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.oValid) n++;
      @(negedge clk);
    end
    check("bp_ignored_op", 32'(n), 32'd0);
    check("bp_ready_after", 32'(bus.oReady), 32'd1);

    // Reset during the divide iterations discards the operation.
    bus.iA = 16'h4200; bus.iB = 16'h3E00; bus.iValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.iValid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(bus.oValid), 32'd0);
    check("rst_mid_ready", 32'(bus.oReady), 32'd1);
    check("rst_mid_z", 32'(bus.oZ), 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.oValid) n++;
      @(negedge clk);
    end
    check("rst_mid_no_result", 32'(n), 32'd0);
    run_op(16'h3C00, 16'h4200, 16'h3555, 5'b00001, 15);
    run_op(16'h4200, 16'h3E00, 16'h4000, 5'b00000, 15);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
